mont_io_stage: RTL

MONT_IO_STAGE -- requirements
Module: mont_io_stage

---
 rtl/mont_io_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mont_io_stage.sv
// Loads 48 stream words into the A/B/M operands, runs the multiplier once, then streams out 16 result words.
// Latency: 48th input transfer -> mont_start next cycle; done sampled -> m_valid two edges later.
// Backpressure: s_ready is high only in LOAD; m_data is held while m_valid is high and m_ready is low.
module mont_io_stage #(
  parameter int WORD_W = 32,
  parameter int OP_W   = 512
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [OP_W-1:0]   mont_a,
  output logic [OP_W-1:0]   mont_b,
  output logic [OP_W-1:0]   mont_m,
  output logic              mont_start,
  output logic              mont_resetn,
  input  logic [OP_W-1:0]   mont_result,
  input  logic              mont_done,
  output logic              busy
);

  localparam int NWORDS = OP_W / WORD_W;
  localparam int IDX_W  = $clog2(NWORDS);
  localparam logic [5:0]       LAST_IN  = 6'(3 * NWORDS - 1);
  localparam logic [IDX_W-1:0] LAST_OUT = IDX_W'(NWORDS - 1);

  typedef enum logic [2:0] {
    LOAD,
    START,
    WAIT,
    CLEAR,
    UNLOAD
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic [5:0]       wordCnt;
  logic [IDX_W-1:0] outIdx;
  logic [OP_W-1:0]  resultReg;

  logic             inXfer;
  logic             outXfer;
  logic             lastIn;
  logic             lastOut;
  logic [1:0]       bank;
  logic [IDX_W-1:0] slot;

  assign inXfer  = s_valid && s_ready;
  assign outXfer = m_valid && m_ready;
  assign lastIn  = inXfer && (wordCnt == LAST_IN);
  assign lastOut = outXfer && (outIdx == LAST_OUT);

  // Word count splits into operand select (A/B/M) and word slot inside that operand.
  assign slot = wordCnt[IDX_W-1:0];
  assign bank = wordCnt[IDX_W+1:IDX_W];

  // Result word currently offered; only outIdx moves it, so it is stable under stall.
  assign m_data = resultReg[outIdx*WORD_W +: WORD_W];

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= LOAD;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic: done is only looked at in WAIT, so a held level cannot re-trigger.
  always_comb begin
    stateNext = state;
    case (state)
      LOAD:    if (lastIn) stateNext = START;
      START:   stateNext = WAIT;
      WAIT:    if (mont_done) stateNext = CLEAR;
      CLEAR:   stateNext = UNLOAD;
      UNLOAD:  if (lastOut) stateNext = LOAD;
      default: stateNext = LOAD;
    endcase
  end

  // State-decoded outputs; all forced inactive while resetn is low.
  always_comb begin
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    mont_start  = 1'b0;
    mont_resetn = 1'b0;
    busy        = 1'b0;
    if (resetn) begin
      s_ready     = (state == LOAD);
      m_valid     = (state == UNLOAD);
      mont_start  = (state == START);
      mont_resetn = (state != CLEAR);
      busy        = (state != LOAD);
    end
  end

  // Input word counter and output word index.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wordCnt <= '0;
      outIdx  <= '0;
    end else begin
      if (inXfer) begin
        wordCnt <= lastIn ? 6'd0 : wordCnt + 6'd1;
      end
      if (lastOut) begin
        outIdx  <= '0;
        wordCnt <= '0;
      end else if (outXfer) begin
        outIdx <= outIdx + 1'b1;
      end
    end
  end

  // Operand registers: written only by LOAD transfers, so they hold through the whole multiply.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mont_a <= '0;
      mont_b <= '0;
      mont_m <= '0;
    end else if (inXfer) begin
      case (bank)
        2'd0:    mont_a[slot*WORD_W +: WORD_W] <= s_data;
        2'd1:    mont_b[slot*WORD_W +: WORD_W] <= s_data;
        default: mont_m[slot*WORD_W +: WORD_W] <= s_data;
      endcase
    end
  end

  // Result capture on the first done seen in WAIT.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      resultReg <= '0;
    end else if ((state == WAIT) && mont_done) begin
      resultReg <= mont_result;
    end
  end

endmodule
